// File: rtl/nco_phase_gen.sv
// Phase accumulator and angle splitter that feeds cosine_int. The sign and
// fine bits are delayed ROM_LAT cycles so they line up with rom_d for ra.
module nco_phase_gen #(
    parameter int NBA     = 22,
    parameter int ROM_LAT = 2
) (
    input  logic              c,
    input  logic              r,
    input  logic              ce,
    input  logic [NBA-1:0]    f,
    input  logic              f_wr,
    input  logic [NBA-1:0]    po,
    input  logic              po_wr,
    input  logic              sync,
    output logic [10:0]       ra,
    output logic [NBA-13:0]   a,
    output logic              s
);

    localparam int NF = NBA - 12;

    logic [NBA-1:0] freq_q, freq_d;
    logic [NBA-1:0] off_q,  off_d;
    logic [NBA-1:0] acc_q,  acc_d;
    logic [NBA-1:0] ph_q,   ph_d;
    logic [ROM_LAT-1:0] sDly_q, sDly_d;
    logic [NF-1:0]      aDly_q [ROM_LAT];
    logic [NF-1:0]      aDly_d [ROM_LAT];

    // Sync clears only the accumulator, so the restart phase equals the offset.
    always_comb begin
        freq_d = freq_q;
        off_d  = off_q;
        acc_d  = acc_q;
        ph_d   = acc_q + off_q;
        if (f_wr) begin
            freq_d = f;
        end
        if (po_wr) begin
            off_d = po;
        end
        if (sync) begin
            acc_d = '0;
        end else if (ce) begin
            acc_d = acc_q + freq_q;
        end
    end

    always_comb begin
        sDly_d    = sDly_q;
        aDly_d    = aDly_q;
        sDly_d[0] = ph_q[NBA-1];
        aDly_d[0] = ph_q[NF-1:0];
        for (int i = 1; i < ROM_LAT; i++) begin
            sDly_d[i] = sDly_q[i-1];
            aDly_d[i] = aDly_q[i-1];
        end
    end

    always_ff @(posedge c) begin
        if (r) begin
            freq_q <= '0;
            off_q  <= '0;
            acc_q  <= '0;
            ph_q   <= '0;
            sDly_q <= '0;
            for (int i = 0; i < ROM_LAT; i++) begin
                aDly_q[i] <= '0;
            end
        end else begin
            freq_q <= freq_d;
            off_q  <= off_d;
            acc_q  <= acc_d;
            ph_q   <= ph_d;
            sDly_q <= sDly_d;
            for (int i = 0; i < ROM_LAT; i++) begin
                aDly_q[i] <= aDly_d[i];
            end
        end
    end

    assign ra = ph_q[NBA-2:NBA-12];
    assign s  = sDly_q[ROM_LAT-1];
    assign a  = aDly_q[ROM_LAT-1];

endmodule

// File: tb/tb_nco_phase_gen.sv
// Directed bench for nco_phase_gen (NBA=22, ROM_LAT=2): vector table plus
// hand-written ramp-wrap and mid-run reset sequences.
module tb_nco_phase_gen;

    logic        c = 1'b0;
    logic        r, ce, fWr, poWr, sync;
    logic [21:0] f, po;
    logic [10:0] ra;
    logic [9:0]  a;
    logic        s;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        r;
        logic        ce;
        logic [21:0] f;
        logic        fWr;
        logic [21:0] po;
        logic        poWr;
        logic        sync;
        logic [10:0] expRa;
        logic [9:0]  expA;
        logic        expS;
    } vec_t;

    vec_t vecs [44];

    nco_phase_gen #(.NBA(22), .ROM_LAT(2)) dut (
        .c(c), .r(r), .ce(ce), .f(f), .f_wr(fWr), .po(po), .po_wr(poWr),
        .sync(sync), .ra(ra), .a(a), .s(s)
    );

    always #5 c = ~c;

    function automatic vec_t mk(input logic vr, input logic vce, input logic [21:0] vf,
                                input logic vfw, input logic [21:0] vpo, input logic vpw,
                                input logic vsy, input logic [10:0] era, input logic [9:0] ea,
                                input logic es);
        vec_t v;
        v.r = vr; v.ce = vce; v.f = vf; v.fWr = vfw; v.po = vpo; v.poWr = vpw;
        v.sync = vsy; v.expRa = era; v.expA = ea; v.expS = es;
        return v;
    endfunction

    // Inputs change 1ns after the rising edge; outputs are read at that point too.
    task automatic applyStimulus(input logic vr, input logic vce, input logic [21:0] vf,
                                 input logic vfw, input logic [21:0] vpo, input logic vpw,
                                 input logic vsy);
        r = vr; ce = vce; f = vf; fWr = vfw; po = vpo; poWr = vpw; sync = vsy;
        @(posedge c);
        #1;
    endtask

    task automatic checkOutput(input string tag, input int idx, input logic [10:0] eRa,
                               input logic [9:0] eA, input logic eS);
        checks += 3;
        if (ra !== eRa) begin
            errors++;
            $display("[TB] FAIL %s[%0d] ra: got %0d, want %0d", tag, idx, ra, eRa);
        end
        if (a !== eA) begin
            errors++;
            $display("[TB] FAIL %s[%0d] a: got 0x%0h, want 0x%0h", tag, idx, a, eA);
        end
        if (s !== eS) begin
            errors++;
            $display("[TB] FAIL %s[%0d] s: got %0b, want %0b", tag, idx, s, eS);
        end
    endtask

    initial begin
        // Reset held with writes pending, then idle, then ramp at 0x400.
        for (int i = 0; i < 3; i++) vecs[i] = mk(1, 1, 22'h000400, 1, 0, 0, 0, 0, 0, 0);
        vecs[3]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[4]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[5]  = mk(0, 1, 22'h000400, 1, 0, 0, 0, 0, 0, 0);
        vecs[6]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[7]  = mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
        vecs[8]  = mk(0, 1, 0, 0, 0, 0, 0, 2, 0, 0);
        vecs[9]  = mk(0, 1, 0, 0, 0, 0, 0, 3, 0, 0);
        // Sync with f=1, then f_wr 0x100 latency, then ce=0 freeze.
        vecs[10] = mk(0, 1, 22'h000001, 1, 0, 0, 1, 4, 0, 0);
        vecs[11] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[12] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[13] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[14] = mk(0, 1, 0, 0, 0, 0, 0, 0, 10'h001, 0);
        vecs[15] = mk(0, 1, 22'h000100, 1, 0, 0, 0, 0, 10'h002, 0);
        vecs[16] = mk(0, 1, 0, 0, 0, 0, 0, 0, 10'h003, 0);
        vecs[17] = mk(0, 1, 0, 0, 0, 0, 0, 0, 10'h004, 0);
        vecs[18] = mk(0, 1, 0, 0, 0, 0, 0, 0, 10'h005, 0);
        vecs[19] = mk(0, 1, 0, 0, 0, 0, 0, 0, 10'h105, 0);
        vecs[20] = mk(0, 1, 0, 0, 0, 0, 0, 1, 10'h205, 0);
        vecs[21] = mk(0, 0, 0, 0, 0, 0, 0, 1, 10'h305, 0);
        vecs[22] = mk(0, 0, 0, 0, 0, 0, 0, 1, 10'h005, 0);
        vecs[23] = mk(0, 0, 0, 0, 0, 0, 0, 1, 10'h105, 0);
        vecs[24] = mk(0, 0, 0, 0, 0, 0, 0, 1, 10'h105, 0);
        // Offset load, then sync together with a new frequency.
        vecs[25] = mk(0, 0, 0, 0, 22'h100000, 1, 0, 1, 10'h105, 0);
        vecs[26] = mk(0, 1, 22'h000400, 1, 0, 0, 1, 1025, 10'h105, 0);
        vecs[27] = mk(0, 1, 0, 0, 0, 0, 0, 1024, 10'h105, 0);
        vecs[28] = mk(0, 1, 0, 0, 0, 0, 0, 1025, 10'h105, 0);
        vecs[29] = mk(0, 1, 0, 0, 0, 0, 0, 1026, 0, 0);
        // Negative frequency with simultaneous f_wr/po_wr/sync.
        vecs[30] = mk(0, 1, 22'h3FFFFF, 1, 0, 1, 1, 1027, 0, 0);
        vecs[31] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[32] = mk(0, 1, 0, 0, 0, 0, 0, 2047, 0, 0);
        vecs[33] = mk(0, 1, 0, 0, 0, 0, 0, 2047, 0, 0);
        vecs[34] = mk(0, 1, 0, 0, 0, 0, 0, 2047, 10'h3FF, 1);
        vecs[35] = mk(0, 1, 0, 0, 0, 0, 0, 2047, 10'h3FE, 1);
        vecs[36] = mk(0, 1, 0, 0, 0, 0, 0, 2047, 10'h3FD, 1);
        // Half-cycle step: sign toggles every cycle.
        vecs[37] = mk(0, 1, 22'h200000, 1, 0, 0, 1, 2047, 10'h3FC, 1);
        vecs[38] = mk(0, 1, 0, 0, 0, 0, 0, 0, 10'h3FB, 1);
        vecs[39] = mk(0, 1, 0, 0, 0, 0, 0, 0, 10'h3FA, 1);
        vecs[40] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[41] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        vecs[42] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[43] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1);

        r = 1; ce = 0; f = 0; fWr = 0; po = 0; poWr = 0; sync = 0;
        @(negedge c);

        for (int i = 0; i < 44; i++) begin
            applyStimulus(vecs[i].r, vecs[i].ce, vecs[i].f, vecs[i].fWr,
                          vecs[i].po, vecs[i].poWr, vecs[i].sync);
            checkOutput("vec", i, vecs[i].expRa, vecs[i].expA, vecs[i].expS);
        end

        // Full ramp at 0x400 through the 2047->0 wrap; sign lags ra by two cycles.
        applyStimulus(0, 1, 22'h000400, 1, 0, 0, 1);
        for (int n = 1; n <= 2100; n++) begin
            applyStimulus(0, 1, 0, 0, 0, 0, 0);
            if (n >= 3) begin
                checkOutput("ramp", n, 11'((n - 1) % 2048), 10'h000, 1'(((n - 3) >> 11) & 1));
            end else begin
                checks++;
                if (ra !== 11'(n - 1)) begin
                    errors++;
                    $display("[TB] FAIL ramp[%0d] ra: got %0d, want %0d", n, ra, n - 1);
                end
            end
        end

        // One-cycle reset mid-ramp; nothing moves until a fresh f_wr.
        applyStimulus(1, 1, 22'h000400, 1, 0, 0, 0);
        checkOutput("midrst", 0, 0, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(0, 1, 0, 0, 0, 0, 0);
            checkOutput("idle", i, 0, 0, 0);
        end
        applyStimulus(0, 1, 22'h000400, 1, 0, 0, 0);
        checkOutput("resume", 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        checkOutput("resume", 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        checkOutput("resume", 2, 1, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        checkOutput("resume", 3, 2, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nco_phase_gen.md
# nco_phase_gen

Phase accumulator and angle splitter that directly feeds `cosine_int`. Each cycle it advances an NBA-bit phase by a programmable frequency word and adds a programmable phase offset. It splits the result into a half-wave ROM address, a sign bit and the fine interpolation bits. The sign and fine bits are delayed so that they arrive at `cosine_int` in the same cycle as the ROM data `rom_d` addressed by `ra`.

## Interface

Parameters:
- NBA, 22: phase/angle width in bits. Minimum 13. Top bit is the sign, next 11 bits are the ROM address, the remaining NBA-12 bits are the fine part.
- ROM_LAT, 2: clock cycles from `ra` to valid `rom_d` in the external ROM. Range 1..4.

Ports:
- c, input, 1: clock. All logic is on the rising edge.
- r, input, 1: reset. Synchronous, active-high.
- ce, input, 1: accumulator advance enable.
- f, input, NBA: frequency word. Unsigned; the phase increment is taken modulo 2^NBA.
- f_wr, input, 1: load `f` into the frequency register.
- po, input, NBA: phase offset word.
- po_wr, input, 1: load `po` into the offset register.
- sync, input, 1: clear the accumulator; the frequency and offset registers are kept.
- ra, output, 11: half-wave cosine ROM address.
- a, output, NBA-12: fine angle bits, aligned to `rom_d`.
- s, output, 1: half-cycle sign, aligned to `rom_d`. 1 means the half-wave value is negated.

## Operation

- The ROM holds cos(θ) for θ in [0, π) as 2048 entries. The output uses cos(θ+π) = −cos(θ) for the second half cycle.
- Registers:
  - `freq`: reset 0. Loaded from `f` when `f_wr` is high.
  - `off`: reset 0. Loaded from `po` when `po_wr` is high.
  - `acc`: reset 0.
    - `r` or `sync` high: `acc <= 0`.
    - Otherwise, `ce` high: `acc <= acc + freq` (mod 2^NBA).
    - Otherwise: hold.
  - `ph`: reset 0. `ph <= acc + off` (mod 2^NBA) every cycle, independent of `ce`.
- Outputs:
  - `ra = ph[NBA-2:NBA-12]`, driven directly from the `ph` register.
  - `s = ph[NBA-1]` and `a = ph[NBA-13:0]`, each passed through a ROM_LAT-deep shift register. The shift register clocks every cycle and is cleared by `r`.
- Arithmetic:
  - All sums are NBA-bit with the carry-out discarded, so the accumulator wraps silently.
  - An `f` value at or above 2^(NBA-1) acts as a negative frequency.
- Simultaneous events:
  - `sync` together with `f_wr`: the accumulator clears and the new frequency is captured. The first increment uses the new frequency.
  - `sync` with `ce` low: the accumulator still clears.
  - `f_wr` and `po_wr` together: both registers load in the same cycle.
  - `r` overrides every other input.
- Reset mid-operation:
  - All registers (`freq`, `off`, `acc`, `ph`, delay lines) go to 0 on the cycle after `r` is sampled high.
  - Outputs read `ra`=0, `a`=0, `s`=0 until non-zero phase propagates.
- No handshake back-pressure: the block never stalls, and `ce` only gates the phase advance.

## Timing

- The `f_wr` write and the accumulator update happen on separate edges:
  - Edge k: `f_wr` is sampled and `freq` loads.
  - Edge k+1: the first `acc` update using the new `freq`.
  - Edge k+2: `ph` reflects it, so `ra` shows the effect 3 cycles after the `f_wr` cycle.
- `po_wr` sampled at edge k changes `ph` at edge k+1, so `ra` shows the effect 2 cycles after the `po_wr` cycle.
- `sync` sampled at edge k: `acc`=0 after edge k and `ph`=`off` after edge k+1. The phase restarts at `off` with deterministic alignment.
- `s` and `a` lag `ra` by exactly ROM_LAT cycles. Together with `rom_d` they form a coherent sample for `cosine_int`.
- Reset to first valid output: `ra` is valid after 2 cycles; `a` and `s` after 2+ROM_LAT cycles.

## Test plan

All scenarios use NBA=22 and ROM_LAT=2.

1. Reset check: assert `r` for 3 cycles with `f_wr`=1, `f`=0x000400 and `ce`=1.
   - Required: `ra`=0, `a`=0, `s`=0, and `freq` stays 0 throughout.
   - After `r` drops, no output moves until an `f_wr` occurs.
2. Steady ramp: write `f`=0x000400, then hold `ce`=1.
   - Required: `ra` steps 0,1,2,… by one per cycle and `a` stays 0.
   - `ra` wraps 2047→0 with `s` toggling.
   - `a`/`s` match a model of `ph` delayed 2 cycles.
3. Wrap and negative frequency:
   - `f`=0x200000: `s` toggles every cycle with `ra`=0.
   - `f`=0x3FFFFF: `acc` decrements by 1 per cycle, and `a` reads 0x3FF, 0x3FE, … after wrap.
4. Frequency-write latency and `ce`: `f`=0x000001 running, then `f_wr` with 0x000100 at cycle k.
   - Required: the first `ph` step of 0x100 is observed at cycle k+3.
   - With `ce`=0, `ra`, `a` and `s` stay frozen at their last values.
5. Sync and offset: `po_wr` with 0x100000 loads the offset, then assert `sync` in the same cycle as `f_wr`.
   - Required: `ra`=1024 and `s`=0 two cycles after `sync`.
   - The next step uses the new `f`.
6. Reset mid-run: assert `r` for 1 cycle during scenario 2.
   - Required: everything is 0 the next cycle, `freq`=0, and the ramp does not resume until a new `f_wr`.
